// File: rtl/switch_debounce_if.sv
// ============================================================================
//  Module      : switch_debounce_if
//  Description : Raw push-button level in, debounced level and strobes out.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface switch_debounce_if;
  logic i_Switch;
  logic o_Switch;
  logic o_Rise;
  logic o_Fall;
  logic o_Busy;

  modport master (
    output i_Switch,
    input  o_Switch, o_Rise, o_Fall, o_Busy
  );

  modport slave (
    input  i_Switch,
    output o_Switch, o_Rise, o_Fall, o_Busy
  );
endinterface

`default_nettype wire

// File: rtl/switch_debounce.sv
// ============================================================================
//  Module      : switch_debounce
//  Description : Two-flop synchroniser plus four-state hold-time filter that
//                publishes a clean level and one-cycle rise/fall strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module switch_debounce #(
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  wire logic   i_Clk,
  input  wire logic   i_Rst,
  switch_debounce_if.slave sw_if
);

  localparam int c_CNT_W = $clog2(DEBOUNCE_LIMIT);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_LIMIT - 1);

  typedef enum logic [1:0] {
    S_LOW     = 2'd0,
    S_RISING  = 2'd1,
    S_HIGH    = 2'd2,
    S_FALLING = 2'd3
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_switch;
  logic                 r_rise;
  logic                 r_fall;
  logic                 r_busy;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_state  <= S_LOW;
      r_cnt    <= '0;
      r_switch <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_sync1 <= sw_if.i_Switch;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;

      case (r_state)
        S_LOW: begin
          if (r_sync2) begin
            r_state <= S_RISING;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end

        S_RISING: begin
          // A single low sample drops the candidate; the next one starts fresh.
          if (!r_sync2) begin
            r_state <= S_LOW;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == c_CNT_LAST) begin
            r_state  <= S_HIGH;
            r_cnt    <= '0;
            r_switch <= 1'b1;
            r_rise   <= 1'b1;
            r_busy   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_HIGH: begin
          if (!r_sync2) begin
            r_state <= S_FALLING;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end

        S_FALLING: begin
          if (r_sync2) begin
            r_state <= S_HIGH;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == c_CNT_LAST) begin
            r_state  <= S_LOW;
            r_cnt    <= '0;
            r_switch <= 1'b0;
            r_fall   <= 1'b1;
            r_busy   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= S_LOW;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign sw_if.o_Switch = r_switch;
  assign sw_if.o_Rise   = r_rise;
  assign sw_if.o_Fall   = r_fall;
  assign sw_if.o_Busy   = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_switch_debounce.sv
// ============================================================================
//  Module      : tb_switch_debounce
//  Description : Self-checking bench for switch_debounce (DEBOUNCE_LIMIT = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_switch_debounce;

  localparam int L = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  switch_debounce_if dut_if ();

  switch_debounce #(.DEBOUNCE_LIMIT(L)) u_dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .sw_if (dut_if)
  );

  wire logic [3:0] w_outs = {dut_if.o_Switch, dut_if.o_Rise, dut_if.o_Fall, dut_if.o_Busy};

  int checks = 0;
  int errors = 0;

  // Reference: the level flips to v once the last L+1 synchronised samples
  // all equal v; busy whenever the newest synchronised sample disagrees.
  bit   mq[$];
  logic m_sw, m_rise, m_fall, m_busy;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      for (int i = 0; i < L + 3; i++) mq.push_back(1'b0);
      m_sw = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_busy = 1'b0;
    end else begin
      bit all1, all0;
      mq.push_back(dut_if.i_Switch);
      void'(mq.pop_front());
      all1 = 1'b1; all0 = 1'b1;
      for (int i = 0; i <= L; i++) begin
        all1 &= mq[i];
        all0 &= !mq[i];
      end
      m_rise = 1'b0; m_fall = 1'b0;
      if (!m_sw && all1) begin
        m_sw = 1'b1; m_rise = 1'b1;
      end else if (m_sw && all0) begin
        m_sw = 1'b0; m_fall = 1'b1;
      end
      m_busy = (mq[L] != m_sw);
    end
  end

  typedef struct {
    logic       sw;
    logic [3:0] exp;  // {o_Switch, o_Rise, o_Fall, o_Busy} after the edge
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic sw, input logic [3:0] exp);
    vec_t v;
    v.sw = sw; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] exp);
    checks++;
    if (w_outs !== exp) begin
      errors++;
      $display("FAIL %s: got sw/rise/fall/busy=%b expected %b at %0t", name, w_outs, exp, $time);
    end
  endtask

  // After reset release with the pad held high: edges k..k+7.
  task automatic check_full_press(input string name);
    logic [3:0] e;
    for (int n = 0; n < 8; n++) begin
      tick();
      if (n < 2)       e = 4'b0000;
      else if (n < 6)  e = 4'b0001;
      else if (n == 6) e = 4'b1100;
      else             e = 4'b1000;
      chk($sformatf("%s_edge%0d", name, n), e);
    end
  endtask

  initial begin
    int run_left;
    logic cur;

    // Clean press / release, bounce rejection, bouncy press.
    add(0,4'b0000); add(0,4'b0000);
    add(1,4'b0000); add(1,4'b0000); add(1,4'b0001); add(1,4'b0001); add(1,4'b0001);
    add(1,4'b0001); add(1,4'b1100); add(1,4'b1000); add(1,4'b1000);
    add(0,4'b1000); add(0,4'b1000); add(0,4'b1001); add(0,4'b1001); add(0,4'b1001);
    add(0,4'b1001); add(0,4'b0010); add(0,4'b0000);
    add(1,4'b0000); add(1,4'b0000); add(1,4'b0001); add(0,4'b0001); add(1,4'b0001);
    add(1,4'b0000); add(0,4'b0001); add(0,4'b0001); add(0,4'b0000); add(0,4'b0000);
    add(1,4'b0000); add(0,4'b0000); add(1,4'b0001); add(0,4'b0000); add(1,4'b0001);
    add(1,4'b0000); add(1,4'b0001); add(1,4'b0001); add(1,4'b0001); add(1,4'b0001);
    add(1,4'b1100); add(1,4'b1000);

    dut_if.i_Switch = 1'b0;
    #1 rst = 1'b1;
    tick(); tick();
    chk("reset_state", 4'b0000);
    rst = 1'b0;
    repeat (4) tick();

    foreach (vecs[i]) begin
      dut_if.i_Switch = vecs[i].sw;
      tick();
      chk($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Asynchronous reset with the pad high, then a full interval on release.
    chk("pre_reset_high", 4'b1000);
    #3 rst = 1'b1;
    #1 chk("async_reset", 4'b0000);
    tick(); tick();
    chk("held_in_reset", 4'b0000);
    rst = 1'b0;
    check_full_press("reset_release");

    // Reset while RISING with the counter at 2.
    dut_if.i_Switch = 1'b0;
    repeat (8) tick();
    chk("low_before_midcount", 4'b0000);
    dut_if.i_Switch = 1'b1;
    repeat (5) tick();
    chk("rising_cnt2", 4'b0001);
    #3 rst = 1'b1;
    #1 chk("reset_midcount", 4'b0000);
    tick();
    rst = 1'b0;
    check_full_press("midcount_recount");

    // Randomised runs against the reference model, with occasional resets.
    run_left = 0;
    cur = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (run_left == 0) begin
        cur = 1'($urandom_range(0, 1));
        run_left = $urandom_range(1, 2 * L);
      end
      dut_if.i_Switch = cur;
      run_left--;
      tick();
      chk("random", {m_sw, m_rise, m_fall, m_busy});
      if (cyc % 500 == 250) begin
        #3 rst = 1'b1;
        #1 chk("random_reset", {m_sw, m_rise, m_fall, m_busy});
        tick();
        rst = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
